// File: rtl/saturn_jump_decoder.sv
// Saturn control-transfer decoder: recognises GOC/GONC/GOTO/GOSUB/GOLONG/
// GOVLNG/GOSUBL/GOSBVL and the RTN family on the instruction nibble stream,
// drives the jump/return handshake toward the PC/RSTK unit and hands every
// other opcode to the main decoder until it retires.
module saturn_jump_decoder (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_clk_en,
   input  logic [3:0] i_phases,
   input  logic       i_bus_busy,
   input  logic       i_exec_unit_busy,
   input  logic [3:0] i_nibble,
   input  logic       i_carry,
   input  logic       i_instr_done,
   output logic       o_jump_instr,
   output logic [2:0] o_jump_length,
   output logic       o_push_pc,
   output logic       o_block_0x,
   output logic       o_rtn_instr,
   output logic       o_foreign
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BLK0,
      ST_BLK8,
      ST_OFFSET,
      ST_SKIP,
      ST_RTN,
      ST_FOREIGN
   } state_e;

   state_e     state_q, state_d;
   logic       jump_q, jump_d;
   logic [2:0] len_q, len_d;
   logic       push_q, push_d;
   logic       blk0_q, blk0_d;
   logic       rtn_q, rtn_d;
   logic       foreign_q, foreign_d;
   logic [2:0] cnt_q, cnt_d;
   logic [1:0] skip_q, skip_d;

   logic adv, nib_edge, ph3_edge, done_edge;
   logic unused_phases;

   assign adv           = i_clk_en && !i_bus_busy && !i_exec_unit_busy;
   assign nib_edge      = adv && i_phases[2];
   assign ph3_edge      = adv && i_phases[3];
   // Retirement of a handed-over opcode is not blocked by bus/exec stalls.
   assign done_edge     = i_clk_en && i_instr_done;
   assign unused_phases = ^i_phases[1:0];

   // Next-state and output-flag decode; everything holds unless its edge fires.
   always_comb begin
      state_d   = state_q;
      jump_d    = jump_q;
      len_d     = len_q;
      push_d    = push_q;
      blk0_d    = blk0_q;
      rtn_d     = rtn_q;
      foreign_d = foreign_q;
      cnt_d     = cnt_q;
      skip_d    = skip_q;
      case (state_q)
         ST_IDLE: begin
            if (nib_edge) begin
               case (i_nibble)
                  4'h0: begin
                     blk0_d  = 1'b1;
                     state_d = ST_BLK0;
                  end
                  4'h4, 4'h5: begin
                     // GOC (4) branches on carry set, GONC (5) on carry clear.
                     if (i_carry ^ i_nibble[0]) begin
                        jump_d  = 1'b1;
                        len_d   = 3'd1;
                        push_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_OFFSET;
                     end else begin
                        skip_d  = 2'd2;
                        state_d = ST_SKIP;
                     end
                  end
                  4'h6, 4'h7: begin
                     jump_d  = 1'b1;
                     len_d   = 3'd2;
                     push_d  = i_nibble[0];
                     cnt_d   = '0;
                     state_d = ST_OFFSET;
                  end
                  4'h8: state_d = ST_BLK8;
                  default: begin
                     foreign_d = 1'b1;
                     state_d   = ST_FOREIGN;
                  end
               endcase
            end
         end
         ST_BLK0: begin
            if (nib_edge) begin
               blk0_d = 1'b0;
               if (i_nibble[3:2] == 2'b00) begin
                  rtn_d   = 1'b1;
                  state_d = ST_RTN;
               end else begin
                  foreign_d = 1'b1;
                  state_d   = ST_FOREIGN;
               end
            end
         end
         ST_BLK8: begin
            if (nib_edge) begin
               // C..F: bit0 selects abs5 over rel4, bit1 selects a call.
               if (i_nibble[3:2] == 2'b11) begin
                  jump_d  = 1'b1;
                  len_d   = i_nibble[0] ? 3'd4 : 3'd3;
                  push_d  = i_nibble[1];
                  cnt_d   = '0;
                  state_d = ST_OFFSET;
               end else begin
                  foreign_d = 1'b1;
                  state_d   = ST_FOREIGN;
               end
            end
         end
         ST_OFFSET: begin
            if (nib_edge) begin
               if (cnt_q == len_q) begin
                  jump_d  = 1'b0;
                  push_d  = 1'b0;
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         ST_SKIP: begin
            if (nib_edge) begin
               skip_d = skip_q - 2'd1;
               if (skip_q == 2'd1) state_d = ST_IDLE;
            end
         end
         ST_RTN: begin
            if (ph3_edge) begin
               rtn_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_FOREIGN: begin
            if (done_edge) begin
               foreign_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs, cleared asynchronously.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= ST_IDLE;
         jump_q    <= 1'b0;
         len_q     <= '0;
         push_q    <= 1'b0;
         blk0_q    <= 1'b0;
         rtn_q     <= 1'b0;
         foreign_q <= 1'b0;
         cnt_q     <= '0;
         skip_q    <= '0;
      end else begin
         state_q   <= state_d;
         jump_q    <= jump_d;
         len_q     <= len_d;
         push_q    <= push_d;
         blk0_q    <= blk0_d;
         rtn_q     <= rtn_d;
         foreign_q <= foreign_d;
         cnt_q     <= cnt_d;
         skip_q    <= skip_d;
      end
   end

   assign o_jump_instr  = jump_q;
   assign o_jump_length = len_q;
   assign o_push_pc     = push_q;
   assign o_block_0x    = blk0_q;
   assign o_rtn_instr   = rtn_q;
   assign o_foreign     = foreign_q;

endmodule

// File: tb/tb_saturn_jump_decoder.sv
// Bench for saturn_jump_decoder: opcode-sequence table, hand-written stall and
// reset sequences, and randomized traffic against a reference model.
module tb_saturn_jump_decoder;

   logic       i_clk = 1'b0;
   logic       i_reset_n, i_clk_en, i_bus_busy, i_exec_unit_busy;
   logic       i_carry, i_instr_done;
   logic [3:0] i_phases, i_nibble;
   logic       o_jump_instr, o_push_pc, o_block_0x, o_rtn_instr, o_foreign;
   logic [2:0] o_jump_length;

   always #5 i_clk = ~i_clk;

   saturn_jump_decoder dut (
      .i_clk            (i_clk),
      .i_reset_n        (i_reset_n),
      .i_clk_en         (i_clk_en),
      .i_phases         (i_phases),
      .i_bus_busy       (i_bus_busy),
      .i_exec_unit_busy (i_exec_unit_busy),
      .i_nibble         (i_nibble),
      .i_carry          (i_carry),
      .i_instr_done     (i_instr_done),
      .o_jump_instr     (o_jump_instr),
      .o_jump_length    (o_jump_length),
      .o_push_pc        (o_push_pc),
      .o_block_0x       (o_block_0x),
      .o_rtn_instr      (o_rtn_instr),
      .o_foreign        (o_foreign)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks what the decoder is waiting for and how many nibbles remain.
   localparam int M_IDLE = 0, M_BLK0 = 1, M_BLK8 = 2, M_JUMP = 3,
                  M_SKIP = 4, M_RTN = 5, M_FOREIGN = 6;
   int         m_mode, m_left;
   logic       m_jump, m_push, m_blk0, m_rtn, m_for;
   logic [2:0] m_len;

   task automatic model_reset();
      m_mode = M_IDLE; m_left = 0;
      m_jump = 0; m_push = 0; m_blk0 = 0; m_rtn = 0; m_for = 0; m_len = 0;
   endtask

   task automatic model_jump(input int len, input logic push);
      m_jump = 1; m_len = 3'(len); m_push = push;
      m_left = len + 1;               // offset nibbles still to come
      m_mode = M_JUMP;
   endtask

   task automatic model_foreign();
      m_for = 1; m_mode = M_FOREIGN;
   endtask

   task automatic model_step();
      bit adv, nib, p3;
      int n;
      adv = i_clk_en && !i_bus_busy && !i_exec_unit_busy;
      nib = adv && i_phases[2];
      p3  = adv && i_phases[3];
      n   = int'(i_nibble);
      case (m_mode)
         M_IDLE: if (nib) begin
            if (n == 0) begin m_blk0 = 1; m_mode = M_BLK0; end
            else if (n == 4 || n == 5) begin
               if ((n == 4 && i_carry) || (n == 5 && !i_carry)) model_jump(1, 0);
               else begin m_mode = M_SKIP; m_left = 2; end
            end
            else if (n == 6) model_jump(2, 0);
            else if (n == 7) model_jump(2, 1);
            else if (n == 8) m_mode = M_BLK8;
            else model_foreign();
         end
         M_BLK0: if (nib) begin
            m_blk0 = 0;
            if (n <= 3) begin m_rtn = 1; m_mode = M_RTN; end
            else model_foreign();
         end
         M_BLK8: if (nib) begin
            if (n == 12) model_jump(3, 0);
            else if (n == 13) model_jump(4, 0);
            else if (n == 14) model_jump(3, 1);
            else if (n == 15) model_jump(4, 1);
            else model_foreign();
         end
         M_JUMP: if (nib) begin
            m_left--;
            if (m_left == 0) begin m_jump = 0; m_push = 0; m_mode = M_IDLE; end
         end
         M_SKIP: if (nib) begin
            m_left--;
            if (m_left == 0) m_mode = M_IDLE;
         end
         M_RTN: if (p3) begin m_rtn = 0; m_mode = M_IDLE; end
         M_FOREIGN: if (i_clk_en && i_instr_done) begin m_for = 0; m_mode = M_IDLE; end
         default: m_mode = M_IDLE;
      endcase
   endtask

   function automatic logic [7:0] dut_vec();
      return {o_jump_instr, o_jump_length, o_push_pc, o_block_0x, o_rtn_instr, o_foreign};
   endfunction

   function automatic logic [7:0] model_vec();
      return {m_jump, m_len, m_push, m_blk0, m_rtn, m_for};
   endfunction

   // One clock: advance the model with the inputs present at the edge, then compare.
   task automatic tick();
      @(posedge i_clk);
      if (i_reset_n) model_step(); else model_reset();
      #1;
      check("cycle_model", 32'(dut_vec()), 32'(model_vec()));
   endtask

   // ---------------- nibble feeder with observation counters ----------------
   int         jcnt, bcnt, rcnt;
   logic [2:0] len_seen;
   logic       push_seen;

   task automatic clear_counts();
      jcnt = 0; bcnt = 0; rcnt = 0; len_seen = 0; push_seen = 0;
   endtask

   // Presents one nibble across phases 0..3 with no stall; counts the flag
   // levels present at each phase-2 / phase-3 edge.
   task automatic feed(input logic [3:0] nib);
      for (int p = 0; p < 4; p++) begin
         i_phases = 4'b0001 << p;
         i_nibble = nib;
         if (p == 2 && o_jump_instr) begin
            jcnt++; len_seen = o_jump_length; push_seen = o_push_pc;
         end
         if (p == 2 && o_block_0x) bcnt++;
         if (p == 3 && o_rtn_instr) rcnt++;
         tick();
      end
   endtask

   typedef struct {
      string       name;
      logic [31:0] nibs;     // nibble k in bits [4k+3:4k]
      int          n;
      logic        carry;
      int          jedges;
      logic [2:0]  len;
      logic        push;
      int          bedges;
      int          redges;
      logic        foreign;
   } vec_t;

   vec_t tbl[15];

   task automatic run_vec(input vec_t v);
      logic [31:0] nibs;
      nibs = v.nibs;
      clear_counts();
      for (int k = 0; k < v.n; k++) begin
         // Carry flips after the opcode nibble; only the opcode edge may use it.
         i_carry = (k == 0) ? v.carry : ~v.carry;
         feed(nibs[4*k +: 4]);
      end
      check({v.name, "_jump_edges"}, 32'(jcnt), 32'(v.jedges));
      if (v.jedges != 0) begin
         check({v.name, "_len"}, 32'(len_seen), 32'(v.len));
         check({v.name, "_push"}, 32'(push_seen), 32'(v.push));
      end
      check({v.name, "_blk0_edges"}, 32'(bcnt), 32'(v.bedges));
      check({v.name, "_rtn_edges"}, 32'(rcnt), 32'(v.redges));
      check({v.name, "_foreign"}, 32'(o_foreign), 32'(v.foreign));
      i_phases = 4'b0001; i_instr_done = 1;
      tick();
      i_instr_done = 0;
      check({v.name, "_idle_after"},
            32'({o_jump_instr, o_push_pc, o_block_0x, o_rtn_instr, o_foreign}), 32'd0);
   endtask

   initial begin
      int ph;
      bit adv;
      tbl[0]  = '{"goto",     32'h00001236, 4, 1'b0, 3, 3'd2, 1'b0, 0, 0, 1'b0};
      tbl[1]  = '{"gosbvl",   32'h010000F8, 7, 1'b0, 5, 3'd4, 1'b1, 0, 0, 1'b0};
      tbl[2]  = '{"goc_nt",   32'h00000BA4, 3, 1'b0, 0, 3'd0, 1'b0, 0, 0, 1'b0};
      tbl[3]  = '{"goc_t",    32'h00000BA4, 3, 1'b1, 2, 3'd1, 1'b0, 0, 0, 1'b0};
      tbl[4]  = '{"rtncc",    32'h00000030, 2, 1'b0, 0, 3'd0, 1'b0, 1, 1, 1'b0};
      tbl[5]  = '{"gosub",    32'h00003217, 4, 1'b0, 3, 3'd2, 1'b1, 0, 0, 1'b0};
      tbl[6]  = '{"golong",   32'h004321C8, 6, 1'b0, 4, 3'd3, 1'b0, 0, 0, 1'b0};
      tbl[7]  = '{"govlng",   32'h054321D8, 7, 1'b0, 5, 3'd4, 1'b0, 0, 0, 1'b0};
      tbl[8]  = '{"gosubl",   32'h004321E8, 6, 1'b0, 4, 3'd3, 1'b1, 0, 0, 1'b0};
      tbl[9]  = '{"gonc_t",   32'h00000215, 3, 1'b0, 2, 3'd1, 1'b0, 0, 0, 1'b0};
      tbl[10] = '{"gonc_nt",  32'h00000215, 3, 1'b1, 0, 3'd0, 1'b0, 0, 0, 1'b0};
      tbl[11] = '{"foreign2", 32'h00000002, 1, 1'b0, 0, 3'd0, 1'b0, 0, 0, 1'b1};
      tbl[12] = '{"blk0_frn", 32'h00000050, 2, 1'b0, 0, 3'd0, 1'b0, 1, 0, 1'b1};
      tbl[13] = '{"blk8_frn", 32'h00000028, 2, 1'b0, 0, 3'd0, 1'b0, 0, 0, 1'b1};
      tbl[14] = '{"rtnsxm",   32'h00000000, 2, 1'b1, 0, 3'd0, 1'b0, 1, 1, 1'b0};

      i_reset_n = 0; i_clk_en = 1; i_bus_busy = 0; i_exec_unit_busy = 0;
      i_carry = 0; i_instr_done = 0; i_phases = 4'b0001; i_nibble = 0;
      model_reset();
      #1;
      check("reset_outputs", 32'(dut_vec()), 32'd0);
      tick(); tick();
      i_reset_n = 1;

      foreach (tbl[i]) run_vec(tbl[i]);

      // Stall in the middle of a GOTO offset: a held phase-2 must not consume.
      clear_counts();
      feed(4'h6); feed(4'h3);
      i_phases = 4'b0100; i_nibble = 4'h2; i_bus_busy = 1;
      for (int s = 0; s < 5; s++) begin
         tick();
         check("stall_hold_jump", 32'(o_jump_instr), 32'd1);
      end
      i_bus_busy = 0;
      feed(4'h2); feed(4'h1);
      check("stall_jump_edges", 32'(jcnt), 32'd3);
      check("stall_jump_end", 32'(o_jump_instr), 32'd0);

      // Asynchronous reset in the middle of a GOVLNG offset.
      clear_counts();
      feed(4'h8); feed(4'hD); feed(4'h0); feed(4'h0);
      check("pre_reset_jump", 32'(o_jump_instr), 32'd1);
      i_phases = 4'b0001;
      #2;
      i_reset_n = 0;
      model_reset();
      #1;
      check("async_reset_clear", 32'(dut_vec()), 32'd0);
      tick(); tick();
      i_reset_n = 1;
      clear_counts();
      feed(4'h6); feed(4'h1); feed(4'h2); feed(4'h3);
      check("post_reset_len", 32'(len_seen), 32'd2);
      check("post_reset_edges", 32'(jcnt), 32'd3);
      check("post_reset_idle", 32'(dut_vec()), 32'(8'b0_010_0000));

      // Randomized traffic with stalls, clock-enable gaps and retire pulses.
      ph = 0;
      for (int c = 0; c < 3000; c++) begin
         i_clk_en         = ($urandom_range(0, 9) != 0);
         i_bus_busy       = ($urandom_range(0, 7) == 0);
         i_exec_unit_busy = ($urandom_range(0, 9) == 0);
         i_carry          = 1'($urandom_range(0, 1));
         i_instr_done     = ($urandom_range(0, 5) == 0);
         i_nibble         = 4'($urandom_range(0, 15));
         i_phases         = 4'b0001 << ph;
         adv = i_clk_en && !i_bus_busy && !i_exec_unit_busy;
         tick();
         if (adv) ph = (ph + 1) % 4;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
